// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
//   Sequences an external 16-bit up-counter as a programmable interval timer.
//   It latches a period, clears the counter for one cycle, then runs it for
//   exactly that many cycles and pulses done. It also supports pause/resume
//   and abort. This block is the only driver of the counter's enable and clear.
//
//   Optional feature: define INTERVAL_TIMER_AUTO_RELOAD_EN to make DONE
//   re-latch period and start the next interval by itself.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       begin an interval (idle) or resume (paused)
//   stop        pause a running interval
//   abort       return to idle from any state
//   period      interval length in cycles, sampled on an accepted start
//   cnt_q       current counter value
//   cnt_enable  counter enable
//   cnt_clear   counter synchronous clear
//   busy        high while an interval is in progress (CLR/RUN/PAUSE/DONE)
//   done        one-cycle completion pulse
//   err         one-cycle pulse on a rejected start or counter inconsistency
//   remaining   period_r - cnt_q while running or paused, else 0
module interval_timer_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] period_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            period_r <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Coinciding abort or stop outranks start.
                    if (start && !stop && !abort) begin
                        if (period == '0) begin
                            err <= 1'b1;
                        end else begin
                            period_r <= period;
                            state    <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    state <= abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    // Completion wins over stop on the last cycle so the
                    // counter never rests at period_r inside PAUSE.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cnt_q >= period_r) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else if (cnt_q == period_r - ONE) begin
                        state <= S_DONE;
                    end else if (stop) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (start && !stop) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
                        if (period == '0) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            period_r <= period;
                            state    <= S_CLR;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decodes of the state register; IDLE after reset forces all zero.
    always_comb begin
        cnt_clear  = (state == S_CLR);
        cnt_enable = (state == S_RUN);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        remaining  = '0;
        if (state == S_RUN || state == S_PAUSE) begin
            remaining = period_r - cnt_q;
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;

    localparam int W = 16;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic         stop    = 1'b0;
    logic         abort   = 1'b0;
    logic [W-1:0] period  = '0;
    logic [W-1:0] cnt_q;
    logic         cnt_enable, cnt_clear, busy, done, err;
    logic [W-1:0] remaining;

    // Counter instance owned by the bench, plus an override to fake corruption.
    logic [W-1:0] cnt         = '0;
    logic         corrupt_en  = 1'b0;
    logic [W-1:0] corrupt_val = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cnt_clear)       cnt <= '0;
        else if (cnt_enable) cnt <= cnt + 1'b1;
    end

    assign cnt_q = corrupt_en ? corrupt_val : cnt;

    interval_timer_ctrl #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .period     (period),
        .cnt_q      (cnt_q),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .remaining  (remaining)
    );

    // Reference model: activity flags of the current interval.
    bit           m_busy, m_clr, m_run, m_paused, m_done, m_err;
    logic [W-1:0] m_per = '0;
    logic [W-1:0] m_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_clr = 0; m_run = 0; m_paused = 0; m_done = 0; m_err = 0;
        m_per = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        logic [W-1:0] cq;
        cq = corrupt_en ? corrupt_val : m_cnt;
        if (m_clr)      m_cnt = '0;
        else if (m_run) m_cnt = m_cnt + 1'b1;
        m_err = 0;
        if (!m_busy) begin
            if (start && !stop && !abort) begin
                if (period == '0) m_err = 1;
                else begin m_per = period; m_busy = 1; m_clr = 1; end
            end
        end else if (abort) begin
            m_busy = 0; m_clr = 0; m_run = 0; m_paused = 0; m_done = 0;
        end else if (m_clr) begin
            m_clr = 0; m_run = 1;
        end else if (m_run) begin
            if (cq >= m_per) begin
                m_err = 1; m_run = 0; m_done = 1;
            end else if (32'(cq) + 1 == 32'(m_per)) begin
                m_run = 0; m_done = 1;
            end else if (stop) begin
                m_run = 0; m_paused = 1;
            end
        end else if (m_paused) begin
            if (start && !stop) begin m_paused = 0; m_run = 1; end
        end else if (m_done) begin
            m_done = 0;
`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
            if (period == '0) begin m_err = 1; m_busy = 0; end
            else begin m_per = period; m_clr = 1; end
`else
            m_busy = 0;
`endif
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] cq, rem_e;
        cq    = corrupt_en ? corrupt_val : m_cnt;
        rem_e = (m_run || m_paused) ? m_per - cq : '0;
        check("cnt_clear",  cnt_clear,  m_clr);
        check("cnt_enable", cnt_enable, m_run);
        check("busy",       busy,       m_busy);
        check("done",       done,       m_done);
        check("err",        err,        m_err);
        check("remaining",  remaining,  rem_e);
        check("cnt_q",      cnt,        m_cnt);
    endtask

    // Inputs change at the falling edge, outputs are checked at the next one.
    task automatic cycle(input bit s, input bit p, input bit a, input logic [W-1:0] per);
        start = s; stop = p; abort = a; period = per;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    int n;
    int dn;
    int dcyc[$];

    initial begin
        model_reset();
        @(negedge clock);
        check_outputs();
        reset_n = 1'b1;
        cycle(0, 0, 0, 16'd5);

        // Basic interval, period 5: done after period+2 edges with cnt_q = 5.
        cycle(1, 0, 0, 16'd5);
        check("clr_first", cnt_clear, 1);
        n = 1;
        while (!done && n < 20) begin cycle(0, 0, 0, 16'd5); n++; end
        check("lat_p5", n, 7);
        check("done_cnt_p5", cnt_q, 5);
        cycle(0, 0, 0, 16'd5);
        check("idle_busy", busy, 0);

        // Zero period is rejected.
        cycle(1, 0, 0, 16'd0);
        check("err_zero", err, 1);
        check("busy_zero", busy, 0);
        cycle(0, 0, 0, 16'd0);
        check("err_once", err, 0);

        // Pause at cnt_q = 3 for 4 cycles, then resume.
        cycle(1, 0, 0, 16'd10);
        n = 1;
        while (!(cnt_enable && cnt_q == 3) && n < 30) begin cycle(0, 0, 0, 16'd10); n++; end
        repeat (4) begin cycle(0, 1, 0, 16'd10); n++; end
        check("pause_cnt", cnt_q, 4);
        check("pause_rem", remaining, 6);
        cycle(1, 0, 0, 16'd10); n++;
        while (!done && n < 60) begin cycle(0, 0, 0, 16'd10); n++; end
        check("lat_pause", n, 16);
        cycle(0, 0, 0, 16'd10);

        // Abort together with start at cnt_q = 7.
        cycle(1, 0, 0, 16'd10);
        n = 1;
        while (!(cnt_enable && cnt_q == 7) && n < 30) begin cycle(0, 0, 0, 16'd10); n++; end
        cycle(1, 0, 1, 16'd10);
        check("abort_busy", busy, 0);
        repeat (2) cycle(0, 0, 0, 16'd10);
        check("abort_cnt", cnt_q, 8);

        // Asynchronous reset in the middle of RUN.
        cycle(1, 0, 0, 16'd10);
        repeat (3) cycle(0, 0, 0, 16'd10);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_outputs();
        check("rst_enable", cnt_enable, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(0, 0, 0, 16'd10);

        // Period changes while busy are ignored.
        cycle(1, 0, 0, 16'd20);
        n = 1;
        while (!done && n < 40) begin cycle(0, 0, 0, 16'd3); n++; end
        check("lat_p20", n, 22);
        check("done_cnt_p20", cnt_q, 20);
        cycle(1, 1, 1, 16'd3);
        cycle(0, 0, 0, 16'd3);

        // Smallest legal period.
        cycle(1, 0, 0, 16'd1);
        n = 1;
        while (!done && n < 10) begin cycle(0, 0, 0, 16'd1); n++; end
        check("lat_p1", n, 3);
        cycle(0, 0, 1, 16'd1);

        // Counter corruption while running.
        cycle(1, 0, 0, 16'd8);
        n = 1;
        while (!(cnt_enable && cnt_q == 2) && n < 20) begin cycle(0, 0, 0, 16'd8); n++; end
        corrupt_en = 1'b1; corrupt_val = 16'd20;
        cycle(0, 0, 0, 16'd8);
        check("corrupt_err", err, 1);
        check("corrupt_done", done, 1);
        corrupt_en = 1'b0;
        cycle(0, 0, 1, 16'd8);
        cycle(0, 0, 0, 16'd8);

`ifdef INTERVAL_TIMER_AUTO_RELOAD_EN
        // Auto reload: done every period+2 cycles until abort.
        cycle(1, 0, 0, 16'd3);
        n = 1;
        while (n < 16) begin
            cycle(0, 0, 0, 16'd3); n++;
            if (done) dcyc.push_back(n);
        end
        check("reload_count", dcyc.size(), 3);
        dn = 5;
        foreach (dcyc[i]) begin check("reload_at", dcyc[i], dn); dn += 5; end
        cycle(0, 0, 1, 16'd3);
        check("reload_abort", busy, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 40) == 0,
                  W'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
